tsc_multicycle_cpu: RTL and testbench

- Multi-cycle TSC CPU that replaces the single-cycle core. Same 16-bit TSC ISA, with the instruction set extended to arithmetic/logic, load/store, branch, jump/link, WWD and HLT.
- Talks to a shared instruction/data memory through a readM/writeM handshake, and exposes num_inst, output_port and is_halted for the testbench.
- Word width and reset PC are parametrised.

---
 rtl/tsc_pkg.sv | 73 +++++++
 rtl/tsc_alu.sv | 34 +++
 rtl/tsc_multicycle_cpu.sv | 233 +++++++++++++++++++++++
 tb/tb_tsc_multicycle_cpu.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared definitions for the multi-cycle TSC core: opcodes, funct codes,
// FSM state encoding and the instruction field view.
package tsc_pkg;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // Field slices within the 16-bit instruction word.
    localparam int OP_MSB  = 15, OP_LSB = 12;
    localparam int RS_MSB  = 11, RS_LSB = 10;
    localparam int RT_MSB  = 9,  RT_LSB = 8;
    localparam int RD_MSB  = 7,  RD_LSB = 6;
    localparam int FN_MSB  = 5;
    localparam int IMM_MSB = 7;
    localparam int TGT_MSB = 11;

    localparam logic [1:0] LINK_REG = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [1:0]  rd;
        logic [5:0]  funct;
        logic [7:0]  imm;
        logic [11:0] target;
    } inst_t;

    function automatic inst_t decode_inst(input logic [15:0] w);
        inst_t f;
        f.op     = w[OP_MSB:OP_LSB];
        f.rs     = w[RS_MSB:RS_LSB];
        f.rt     = w[RT_MSB:RT_LSB];
        f.rd     = w[RD_MSB:RD_LSB];
        f.funct  = w[FN_MSB:0];
        f.imm    = w[IMM_MSB:0];
        f.target = w[TGT_MSB:0];
        return f;
    endfunction

endpackage

// File: rtl/tsc_alu.sv
// Combinational ALU for the R-type arithmetic/logic group; sel is funct[2:0].
module tsc_alu
    import tsc_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [2:0]           sel,
    output logic [WORD_SIZE-1:0] result
);
    localparam logic [2:0] S_ADD = FN_ADD[2:0];
    localparam logic [2:0] S_SUB = FN_SUB[2:0];
    localparam logic [2:0] S_AND = FN_AND[2:0];
    localparam logic [2:0] S_ORR = FN_ORR[2:0];
    localparam logic [2:0] S_NOT = FN_NOT[2:0];
    localparam logic [2:0] S_TCP = FN_TCP[2:0];
    localparam logic [2:0] S_SHL = FN_SHL[2:0];
    localparam logic [2:0] S_SHR = FN_SHR[2:0];

    always_comb begin
        result = '0;
        case (sel)
            S_ADD: result = a + b;
            S_SUB: result = a - b;
            S_AND: result = a & b;
            S_ORR: result = a | b;
            S_NOT: result = ~a;
            S_TCP: result = -a;
            S_SHL: result = {a[WORD_SIZE-2:0], 1'b0};
            S_SHR: result = {a[WORD_SIZE-1], a[WORD_SIZE-1:1]};
        endcase
    end
endmodule

// File: rtl/tsc_multicycle_cpu.sv
// Multi-cycle TSC core: FETCH/DECODE/EXEC/MEM/WB FSM over a shared memory
// with a readM/writeM handshake, 4-entry register file and retire counter.
module tsc_multicycle_cpu
    import tsc_pkg::*;
#(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [WORD_SIZE-1:0] output_port,
    output logic                 is_halted
);
    localparam int W = WORD_SIZE;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d, npc_q, npc_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [W-1:0]   num_q, num_d, out_q, out_d;
    logic [15:0]    ir_q, ir_d;
    logic [1:0]     dst_q, dst_d;
    logic           rd_q, rd_d, wr_q, wr_d, halt_q, halt_d;
    logic [W-1:0]   rf_q [4];
    logic [W-1:0]   rf_d [4];

    inst_t          f;
    logic [W-1:0]   sext_imm, pc_inc, br_tgt, jmp_tgt, alu_res, next_pc;
    logic           br_taken, retire;

    assign f        = decode_inst(ir_q);
    assign sext_imm = W'($signed(f.imm));
    assign pc_inc   = pc_q + W'(1);
    assign br_tgt   = pc_inc + sext_imm;
    assign jmp_tgt  = {pc_q[W-1:12], f.target};

    tsc_alu #(.WORD_SIZE(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sel    (f.funct[2:0]),
        .result (alu_res)
    );

    always_comb begin
        case (f.op)
            OP_BNE:  br_taken = (a_q != b_q);
            OP_BEQ:  br_taken = (a_q == b_q);
            OP_BGZ:  br_taken = ($signed(a_q) > 0);
            OP_BLZ:  br_taken = a_q[W-1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        num_d   = num_q;
        out_d   = out_q;
        ir_d    = ir_q;
        dst_d   = dst_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        halt_d  = halt_q;
        rf_d    = rf_q;
        retire  = 1'b0;
        next_pc = pc_inc;

        case (state_q)
            FETCH: begin
                // After reset the request is raised one cycle late so readM is low first.
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = pc_q;
                end else if (inputReady) begin
                    ir_d    = data[15:0];
                    rd_d    = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rf_q[f.rs];
                b_d     = rf_q[f.rt];
                state_d = EXEC;
            end
            EXEC: begin
                npc_d = pc_inc;
                case (f.op)
                    OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
                        retire  = 1'b1;
                        next_pc = br_taken ? br_tgt : pc_inc;
                    end
                    OP_ADI: begin res_d = a_q + sext_imm;   dst_d = f.rt; state_d = WB; end
                    OP_ORI: begin res_d = a_q | W'(f.imm);  dst_d = f.rt; state_d = WB; end
                    OP_LHI: begin res_d = W'({f.imm, 8'h00}); dst_d = f.rt; state_d = WB; end
                    OP_LWD: begin
                        addr_d  = a_q + sext_imm;
                        rd_d    = 1'b1;
                        dst_d   = f.rt;
                        state_d = MEM;
                    end
                    OP_SWD: begin
                        addr_d  = a_q + sext_imm;
                        wdata_d = b_q;
                        wr_d    = 1'b1;
                        state_d = MEM;
                    end
                    OP_JMP: begin retire = 1'b1; next_pc = jmp_tgt; end
                    OP_JAL: begin
                        res_d   = pc_inc;
                        dst_d   = LINK_REG;
                        npc_d   = jmp_tgt;
                        state_d = WB;
                    end
                    OP_RTYPE: begin
                        if (f.funct <= FN_SHR) begin
                            res_d   = alu_res;
                            dst_d   = f.rd;
                            state_d = WB;
                        end else if (f.funct == FN_JPR) begin
                            retire  = 1'b1;
                            next_pc = a_q;
                        end else if (f.funct == FN_JRL) begin
                            // A already holds the old rs, so rs=$2 targets the pre-link value.
                            res_d   = pc_inc;
                            dst_d   = LINK_REG;
                            npc_d   = a_q;
                            state_d = WB;
                        end else if (f.funct == FN_WWD) begin
                            out_d  = a_q;
                            retire = 1'b1;
                        end else if (f.funct == FN_HLT) begin
                            num_d   = num_q + W'(1);
                            halt_d  = 1'b1;
                            state_d = HALT;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                    default: retire = 1'b1;
                endcase
            end
            MEM: begin
                if (rd_q && inputReady) begin
                    res_d   = data;
                    rd_d    = 1'b0;
                    state_d = WB;
                end else if (wr_q && ackOutput) begin
                    wr_d    = 1'b0;
                    retire  = 1'b1;
                    next_pc = npc_q;
                end
            end
            WB: begin
                rf_d[dst_q] = res_q;
                retire      = 1'b1;
                next_pc     = npc_q;
            end
            default: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        endcase

        // Retiring launches the next fetch in the same edge to keep FETCH wait-free.
        if (retire) begin
            num_d   = num_q + W'(1);
            pc_d    = next_pc;
            state_d = FETCH;
            rd_d    = 1'b1;
            addr_d  = next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            npc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            num_q   <= '0;
            out_q   <= '0;
            ir_q    <= '0;
            dst_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            halt_q  <= 1'b0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            num_q   <= num_d;
            out_q   <= out_d;
            ir_q    <= ir_d;
            dst_q   <= dst_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            halt_q  <= halt_d;
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign readM       = rd_q;
    assign writeM      = wr_q;
    assign address     = addr_q;
    assign data        = wr_q ? wdata_q : 'z;
    assign num_inst    = num_q;
    assign output_port = out_q;
    assign is_halted   = halt_q;

endmodule

// File: tb/tb_tsc_multicycle_cpu.sv
// Scoreboarded bench: an ISA-level model predicts memory traffic and retire
// results; a monitor compares them against the core's bus and outputs.
module tb_tsc_multicycle_cpu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        readM, writeM, is_halted;
    logic        inputReady = 1'b0, ackOutput = 1'b0;
    logic [15:0] address, num_inst, output_port;
    wire  [15:0] data;
    logic        tb_drive = 1'b0;
    logic [15:0] tb_data = '0;

    assign data = tb_drive ? tb_data : 'z;

    tsc_multicycle_cpu #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
        .address(address), .data(data), .inputReady(inputReady),
        .ackOutput(ackOutput), .num_inst(num_inst),
        .output_port(output_port), .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h expected=none", name, act);
    endtask

    logic [15:0] mem     [4096];
    logic [15:0] ref_mem [4096];
    int          fixed_wait = 0;      // <0 selects random 0..2 wait cycles
    logic        stall_en = 1'b0;
    logic [15:0] stall_addr = '0;
    logic        checking = 1'b0;

    logic [15:0] exp_rd  [$];
    logic [31:0] exp_wr  [$];
    logic [31:0] exp_ret [$];

    function automatic logic [15:0] I(input logic [3:0] op, input logic [1:0] rs,
                                      input logic [1:0] rt, input logic [7:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [15:0] R(input logic [1:0] rs, input logic [1:0] rt,
                                      input logic [1:0] rd, input logic [5:0] fn);
        return {4'hF, rs, rt, rd, fn};
    endfunction
    function automatic logic [15:0] J(input logic [3:0] op, input logic [11:0] tgt);
        return {op, tgt};
    endfunction

    // Instruction-level interpreter: one loop iteration per instruction.
    task automatic run_model(input int maxn, output bit halted, output logic [15:0] cnt);
        logic [15:0] r [4];
        logic [15:0] pc, npc, ins, s, ea, t, outp;
        logic [3:0]  op;
        logic [1:0]  rs, rt, rd;
        logic [7:0]  imm;
        halted = 0; cnt = 0; pc = 16'h0000; outp = 0;
        for (int k = 0; k < 4; k++) r[k] = 0;
        ref_mem = mem;
        for (int n = 0; n < maxn; n++) begin
            exp_rd.push_back(pc);
            ins = ref_mem[pc[11:0]];
            op = ins[15:12]; rs = ins[11:10]; rt = ins[9:8]; rd = ins[7:6]; imm = ins[7:0];
            s = {{8{imm[7]}}, imm};
            npc = pc + 16'd1;
            case (op)
                0:  if (r[rs] != r[rt]) npc = pc + 16'd1 + s;
                1:  if (r[rs] == r[rt]) npc = pc + 16'd1 + s;
                2:  if ($signed(r[rs]) > 0) npc = pc + 16'd1 + s;
                3:  if ($signed(r[rs]) < 0) npc = pc + 16'd1 + s;
                4:  r[rt] = r[rs] + s;
                5:  r[rt] = r[rs] | {8'h00, imm};
                6:  r[rt] = {imm, 8'h00};
                7:  begin ea = r[rs] + s; exp_rd.push_back(ea); r[rt] = ref_mem[ea[11:0]]; end
                8:  begin ea = r[rs] + s; exp_wr.push_back({ea, r[rt]}); ref_mem[ea[11:0]] = r[rt]; end
                9:  npc = {pc[15:12], ins[11:0]};
                10: begin r[2] = pc + 16'd1; npc = {pc[15:12], ins[11:0]}; end
                15: case (ins[5:0])
                        0:  r[rd] = r[rs] + r[rt];
                        1:  r[rd] = r[rs] - r[rt];
                        2:  r[rd] = r[rs] & r[rt];
                        3:  r[rd] = r[rs] | r[rt];
                        4:  r[rd] = ~r[rs];
                        5:  r[rd] = 16'd0 - r[rs];
                        6:  r[rd] = r[rs] * 16'd2;
                        7:  r[rd] = $signed(r[rs]) >>> 1;
                        25: npc = r[rs];
                        26: begin t = r[rs]; r[2] = pc + 16'd1; npc = t; end
                        28: outp = r[rs];
                        29: halted = 1;
                        default: ;
                    endcase
                default: ;
            endcase
            cnt = cnt + 16'd1;
            exp_ret.push_back({cnt, outp});
            if (halted) return;
            pc = npc;
        end
        exp_rd.push_back(pc);   // the fetch that follows the last modelled instruction
    endtask

    // Memory responder: drives handshakes just after each rising edge.
    initial begin
        int          need, cnt;
        bit          pend;
        logic [15:0] paddr;
        need = 0; cnt = 0; pend = 0; paddr = 0;
        forever begin
            @(posedge clk); #1;
            if (inputReady || ackOutput) pend = 0;
            inputReady = 1'b0; ackOutput = 1'b0; tb_drive = 1'b0;
            if (!reset_n) begin
                pend = 0;
            end else if (readM || writeM) begin
                if (!pend) begin
                    pend = 1; paddr = address; cnt = 0;
                    need = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                end else if (checking) begin
                    check("addr_hold", address, paddr);
                end
                if (readM && stall_en && address == stall_addr) begin
                end else if (cnt >= need) begin
                    if (readM) begin
                        inputReady = 1'b1; tb_data = mem[address[11:0]]; tb_drive = 1'b1;
                    end else begin
                        ackOutput = 1'b1; mem[address[11:0]] = data;
                    end
                end else begin
                    cnt++;
                end
            end else if (pend && checking) begin
                fail_now("req_dropped", paddr);
                pend = 0;
            end
        end
    end

    // Monitor: compares each handshake and retirement against the scoreboard.
    initial begin
        logic [15:0] prev_num;
        logic [31:0] e;
        prev_num = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_num = 0;
            end else if (checking) begin
                check("rw_exclusive", {31'd0, readM & writeM}, 32'd0);
                if (readM && inputReady) begin
                    if (exp_rd.size() == 0) fail_now("unexpected_read", address);
                    else check("read_addr", address, exp_rd.pop_front());
                end
                if (writeM && ackOutput) begin
                    if (exp_wr.size() == 0) fail_now("unexpected_write", address);
                    else begin
                        e = exp_wr.pop_front();
                        check("write_addr", address, e[31:16]);
                        check("write_data", data, e[15:0]);
                    end
                end
                if (num_inst != prev_num) begin
                    if (exp_ret.size() == 0) fail_now("unexpected_retire", num_inst);
                    else check("retire_num_out", {num_inst, output_port}, exp_ret.pop_front());
                    prev_num = num_inst;
                end
            end else begin
                prev_num = num_inst;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Core is in reset on entry and is put back into reset on exit.
    task automatic run_prog(input string name, input int maxn);
        bit          h;
        logic [15:0] cnt;
        int          cyc;
        exp_rd.delete(); exp_wr.delete(); exp_ret.delete();
        run_model(maxn, h, cnt);
        @(posedge clk); #2;
        reset_n = 1'b1; checking = 1'b1;
        cyc = 0;
        while ((exp_ret.size() + exp_rd.size() + exp_wr.size()) != 0 && cyc < 20000) begin
            @(posedge clk); #2; cyc++;
        end
        if (cyc >= 20000) fail_now({name, "_timeout"}, exp_ret.size());
        if (h) begin
            check({name, "_halted"}, is_halted, 1);
            repeat (6) begin
                @(posedge clk); #2;
                check({name, "_halt_noread"}, readM, 0);
            end
            check({name, "_num_frozen"}, num_inst, cnt);
        end
        checking = 1'b0;
        reset_n  = 1'b0;
    endtask

    task automatic load_alu();
        clear_mem();
        mem[0] = I(6, 0, 0, 8'h12);
        mem[1] = I(4, 0, 0, 8'h34);
        mem[2] = I(4, 1, 1, 8'hFF);
        mem[3] = R(0, 1, 2, 6'd0);
        mem[4] = R(2, 0, 0, 6'd28);
        mem[5] = R(0, 0, 0, 6'd29);
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0]  op;
        logic [5:0]  fns [13];
        logic [15:0] w;
        fns = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd25, 6'd26, 6'd28, 6'd29, 6'd13};
        op = 4'($urandom_range(0, 15));
        w  = 16'($urandom());
        w[15:12] = op;
        if (op <= 3) w[7:0] = 8'($urandom_range(0, 6) - 3);
        if (op == 9 || op == 10) w[11:0] = 12'($urandom_range(0, 23));
        if (op == 15) w[5:0] = ($urandom_range(0, 9) == 0) ? 6'd29 : fns[$urandom_range(0, 12)];
        return w;
    endfunction

    initial begin
        int cyc;
        clear_mem();
        reset_n = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_num_inst", num_inst, 0);
        check("rst_output_port", output_port, 0);
        check("rst_is_halted", is_halted, 0);

        fixed_wait = 0;
        load_alu();
        run_prog("alu", 100);
        check("alu_out", output_port, 16'h1233);

        fixed_wait = 3;
        load_alu();
        run_prog("alu_wait", 100);
        check("alu_wait_out", output_port, 16'h1233);

        fixed_wait = 0;
        clear_mem();
        mem[0] = I(5, 0, 0, 8'hAA);
        mem[1] = I(8, 3, 0, 8'h05);
        mem[2] = I(7, 3, 1, 8'h05);
        mem[3] = R(1, 0, 0, 6'd28);
        mem[4] = R(0, 0, 0, 6'd29);
        run_prog("ldst", 100);
        check("ldst_out", output_port, 16'h00AA);

        clear_mem();
        mem[0]  = J(9, 12'd10);
        mem[10] = I(1, 0, 0, 8'hFE);
        mem[9]  = J(9, 12'd20);
        mem[20] = I(0, 0, 0, 8'h03);
        mem[21] = I(6, 0, 1, 8'h80);
        mem[22] = I(3, 1, 0, 8'h02);
        mem[23] = R(0, 0, 0, 6'd28);
        mem[25] = R(1, 0, 0, 6'd28);
        mem[26] = R(0, 0, 0, 6'd29);
        run_prog("branch", 100);
        check("branch_out", output_port, 16'h8000);

        clear_mem();
        mem[16'h00] = J(9, 12'h020);
        mem[16'h20] = J(10, 12'h040);
        mem[16'h40] = R(2, 0, 0, 6'd26);
        mem[16'h21] = R(2, 0, 0, 6'd28);
        mem[16'h22] = R(0, 0, 0, 6'd29);
        run_prog("jump", 100);
        check("jump_out", output_port, 16'h0041);

        fixed_wait = -1;
        for (int t = 0; t < 10; t++) begin
            clear_mem();
            for (int i = 0; i < 24; i++) mem[i] = rand_inst();
            run_prog("rand", 80);
        end

        // Reset while an LWD read is stalled.
        fixed_wait = 0;
        clear_mem();
        mem[0] = I(5, 0, 0, 8'h5A);
        mem[1] = R(0, 0, 0, 6'd28);
        mem[2] = I(7, 0, 1, 8'h30);
        stall_addr = 16'h008A; stall_en = 1'b1;
        @(posedge clk); #2;
        reset_n = 1'b1;
        cyc = 0;
        while (!(readM && address == 16'h008A) && cyc < 200) begin
            @(posedge clk); #2; cyc++;
        end
        if (cyc >= 200) fail_now("lwd_stall_timeout", address);
        repeat (2) @(posedge clk);
        #2;
        check("lwd_pending", readM, 1);
        check("lwd_out_before", output_port, 16'h005A);
        reset_n = 1'b0;
        @(posedge clk); #2;
        check("rst2_readM", readM, 0);
        check("rst2_writeM", writeM, 0);
        check("rst2_num_inst", num_inst, 0);
        check("rst2_output_port", output_port, 0);
        check("rst2_is_halted", is_halted, 0);
        stall_en = 1'b0;
        reset_n = 1'b1;
        cyc = 0;
        while (!readM && cyc < 20) begin
            @(posedge clk); #2; cyc++;
        end
        check("restart_fetch_addr", {readM, address}, {1'b1, 16'h0000});
        reset_n = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
